wallace_five: RTL and testbench

- 5x5 unsigned multiplier built as a Wallace tree: partial-product AND array, carry-save reduction with full/half adders, final carry-propagate adder.
- Registered 10-bit product output.
- Arithmetic building block for the processor datapath (multiply unit); purely data-driven, no handshake.

---
 rtl/wallace_five.sv | 92 +++++++++
 tb/tb_wallace_five.sv | 100 ++++++++++
 2 files changed

// File: rtl/wallace_five.sv
// wallace_five: registered 5x5 unsigned Wallace-tree multiplier (partial products, CSA reduction, ripple add).
// Define WALLACE_FIVE_PIPE_EN to register the two reduced rows before the final adder (latency 2).
module wallace_five_ha (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module wallace_five_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic x;
  assign x   = a_i ^ b_i;
  assign s_o = x ^ c_i;
  assign c_o = (a_i & b_i) | (x & c_i);
endmodule

module wallace_five (
  input  logic       clock,
  input  logic       resetn,
  input  logic [4:0] in1,
  input  logic [4:0] in2,
  output logic [9:0] out
);
  logic [4:0][4:0] pp;
  logic s1a_s, s1a_c, s1b_s, s1b_c, s1c_s, s1c_c, s1d_s, s1d_c, s1e_s, s1e_c, s1f_s, s1f_c;
  logic s2a_s, s2a_c, s2b_s, s2b_c, s2c_s, s2c_c, s2d_s, s2d_c;
  logic s3a_s, s3a_c, s3b_s, s3b_c;
  logic [9:0] row_a_d, row_b_d, add_a, add_b, out_d, out_q;
  logic [9:0] cy;

  // pp[i][j] carries weight 2^(i+j): row i is in1 gated by in2[i]
  for (genvar i = 0; i < 5; i++) begin : g_pp
    assign pp[i] = in1 & {5{in2[i]}};
  end

  wallace_five_fa u_s1a (.a_i(pp[0][2]), .b_i(pp[1][1]), .c_i(pp[2][0]), .s_o(s1a_s), .c_o(s1a_c));
  wallace_five_fa u_s1b (.a_i(pp[0][3]), .b_i(pp[1][2]), .c_i(pp[2][1]), .s_o(s1b_s), .c_o(s1b_c));
  wallace_five_fa u_s1c (.a_i(pp[0][4]), .b_i(pp[1][3]), .c_i(pp[2][2]), .s_o(s1c_s), .c_o(s1c_c));
  wallace_five_ha u_s1d (.a_i(pp[3][1]), .b_i(pp[4][0]), .s_o(s1d_s), .c_o(s1d_c));
  wallace_five_fa u_s1e (.a_i(pp[1][4]), .b_i(pp[2][3]), .c_i(pp[3][2]), .s_o(s1e_s), .c_o(s1e_c));
  wallace_five_fa u_s1f (.a_i(pp[2][4]), .b_i(pp[3][3]), .c_i(pp[4][2]), .s_o(s1f_s), .c_o(s1f_c));

  wallace_five_fa u_s2a (.a_i(s1b_s), .b_i(pp[3][0]), .c_i(s1a_c), .s_o(s2a_s), .c_o(s2a_c));
  wallace_five_fa u_s2b (.a_i(s1c_s), .b_i(s1d_s), .c_i(s1b_c), .s_o(s2b_s), .c_o(s2b_c));
  wallace_five_fa u_s2c (.a_i(s1e_s), .b_i(pp[4][1]), .c_i(s1c_c), .s_o(s2c_s), .c_o(s2c_c));
  wallace_five_fa u_s2d (.a_i(pp[3][4]), .b_i(pp[4][3]), .c_i(s1f_c), .s_o(s2d_s), .c_o(s2d_c));

  wallace_five_fa u_s3a (.a_i(s2c_s), .b_i(s1d_c), .c_i(s2b_c), .s_o(s3a_s), .c_o(s3a_c));
  wallace_five_fa u_s3b (.a_i(s1f_s), .b_i(s1e_c), .c_i(s2c_c), .s_o(s3b_s), .c_o(s3b_c));

  assign row_a_d = {1'b0, pp[4][4], s2d_s, s3b_s, s3a_s, s2b_s, s2a_s, s1a_s, pp[0][1], pp[0][0]};
  assign row_b_d = {1'b0, s2d_c, s3b_c, s3a_c, 1'b0, s2a_c, 2'b00, pp[1][0], 1'b0};

`ifdef WALLACE_FIVE_PIPE_EN
  logic [9:0] row_a_q, row_b_q;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      row_a_q <= '0;
      row_b_q <= '0;
    end else begin
      row_a_q <= row_a_d;
      row_b_q <= row_b_d;
    end
  assign add_a = row_a_q;
  assign add_b = row_b_q;
`else
  assign add_a = row_a_d;
  assign add_b = row_b_d;
`endif

  assign cy[0] = 1'b0;
  for (genvar k = 0; k < 9; k++) begin : g_cpa
    wallace_five_fa u_cpa (.a_i(add_a[k]), .b_i(add_b[k]), .c_i(cy[k]), .s_o(out_d[k]), .c_o(cy[k+1]));
  end
  // 31*31 < 1024, so the top bit never produces a carry
  assign out_d[9] = add_a[9] ^ add_b[9] ^ cy[9];

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) out_q <= '0;
    else out_q <= out_d;

  assign out = out_q;
endmodule

// File: tb/tb_wallace_five.sv
// tb_wallace_five: scoreboard bench for wallace_five; driver queues expected products, monitor pops at latency.
module tb_wallace_five;
`ifdef WALLACE_FIVE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic [4:0] in1 = '0, in2 = '0;
  logic [9:0] out;
  logic       issue = 1'b0;
  logic [1:0] pipe = '0;
  logic [19:0] exp_q[$];
  logic [19:0] e;
  int checks = 0, passed = 0;

  wallace_five dut (.clock(clock), .resetn(resetn), .in1(in1), .in2(in2), .out(out));

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: out=%0d expected %0d", nm, act, expv);
  endtask

  task automatic op(input logic [4:0] a, input logic [4:0] b, input logic [9:0] p);
    @(negedge clock);
    #1;
    in1 = a;
    in2 = b;
    issue = 1'b1;
    exp_q.push_back({a, b, p});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
      issue = 1'b0;
    end
  endtask

  // bench-side marker of which edges carry a result; mirrors the reset flush
  always @(posedge clock or negedge resetn)
    if (!resetn) pipe <= '0;
    else pipe <= {pipe[0], issue};

  always @(negedge clock)
    if (pipe[LAT-1]) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_underflow: out=%0d expected no result", out);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("prod %0d*%0d", e[19:15], e[14:10]), out, e[9:0]);
      end
    end

  initial begin
    in1 = 5'd31;
    in2 = 5'd31;
    #1 resetn = 1'b0;
    #1 chk("async_reset", out, 10'd0);
    @(negedge clock);
    #1 resetn = 1'b1;
    issue = 1'b1;
    exp_q.push_back({5'd31, 5'd31, 10'd961});
    op(5'd0, 5'd20, 10'd0);
    op(5'd31, 5'd1, 10'd31);
    op(5'd1, 5'd27, 10'd27);
    op(5'd25, 5'd16, 10'd400);
    op(5'd21, 5'd27, 10'd567);
    op(5'd17, 5'd19, 10'd323);
    op(5'd31, 5'd31, 10'd961);
    op(5'd16, 5'd16, 10'd256);
    op(5'd31, 5'd0, 10'd0);
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        op(5'(a), 5'(b), 10'(a * b));
    op(5'd7, 5'd9, 10'd63);
    @(negedge clock);
    #1 issue = 1'b0;
    resetn = 1'b0;
    exp_q.delete();
    #1 chk("mid_reset", out, 10'd0);
    #2 resetn = 1'b1;
    op(5'd12, 5'd13, 10'd156);
    op(5'd9, 5'd30, 10'd270);
    op(5'd30, 5'd31, 10'd930);
    idle(LAT + 3);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL sb_drain: pending=%0d expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
